// File: rtl/ws2812_rx.sv
// ws2812_rx: receiver/decoder for the single-wire WS2812-style NRZ pixel stream.
// Classifies each high pulse by width (glitch / 0 / 1 / stuck-high), assembles
// 24-bit pixels MSB-first and latches a whole frame once the line idles low for
// RESET_CYCLES clocks.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   din          serial line, asynchronous to clk
//   frame_rgb    last latched frame, pixel 0 in the top 24 bits
//   frame_valid  one-cycle pulse when frame_rgb updates
//   frame_count  complete pixels in the latched frame, capped at NUM_LEDS
//   pixel        most recently completed pixel
//   pixel_index  slot of that pixel (0-based)
//   pixel_valid  one-cycle pulse per completed in-range pixel
//   err          one-cycle error pulse
//   err_code     latest error: 01 glitch, 10 stuck high, 11 partial pixel
module ws2812_rx #(
  parameter int unsigned NUM_LEDS     = 6,
  parameter int unsigned MIN_HIGH     = 6,
  parameter int unsigned BIT_THRESH   = 29,
  parameter int unsigned MAX_HIGH     = 96,
  parameter int unsigned RESET_CYCLES = 2400
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     din,
  output logic [24*NUM_LEDS-1:0]   frame_rgb,
  output logic                     frame_valid,
  output logic [7:0]               frame_count,
  output logic [23:0]              pixel,
  output logic [7:0]               pixel_index,
  output logic                     pixel_valid,
  output logic                     err,
  output logic [1:0]               err_code
);

  localparam int unsigned FW     = 24 * NUM_LEDS;
  localparam logic [7:0]  HMin   = 8'(MIN_HIGH);
  localparam logic [7:0]  HThr   = 8'(BIT_THRESH);
  localparam logic [7:0]  HMax   = 8'(MAX_HIGH);
  localparam logic [7:0]  HSat   = 8'(MAX_HIGH + 1);
  localparam logic [7:0]  NLeds  = 8'(NUM_LEDS);
  localparam logic [15:0] LReset = 16'(RESET_CYCLES);

  typedef enum logic [1:0] {StSync, StReady, StHigh, StLow} state_e;

  logic [1:0]    sync_q;
  logic          din_s, din_q, rise, fall;
  state_e        state_q, state_d;
  logic [7:0]    hcnt_q, hcnt_d;
  logic [15:0]   lcnt_q, lcnt_d;
  logic [4:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    pixcnt_q, pixcnt_d;
  logic [22:0]   shift_q, shift_d;
  logic [FW-1:0] shadow_q, shadow_d;
  logic [23:0]   word;

  logic [FW-1:0] frame_rgb_q, frame_rgb_d;
  logic          frame_valid_q, frame_valid_d;
  logic [7:0]    frame_count_q, frame_count_d;
  logic [23:0]   pixel_q, pixel_d;
  logic [7:0]    pixel_index_q, pixel_index_d;
  logic          pixel_valid_q, pixel_valid_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;

  assign din_s = sync_q[1];
  assign rise  = din_s & ~din_q;
  assign fall  = ~din_s & din_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q        <= '0;
      din_q         <= 1'b0;
      state_q       <= StSync;
      hcnt_q        <= '0;
      lcnt_q        <= '0;
      bitcnt_q      <= '0;
      pixcnt_q      <= '0;
      shift_q       <= '0;
      shadow_q      <= '0;
      frame_rgb_q   <= '0;
      frame_valid_q <= 1'b0;
      frame_count_q <= '0;
      pixel_q       <= '0;
      pixel_index_q <= '0;
      pixel_valid_q <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= '0;
    end else begin
      sync_q        <= {sync_q[0], din};
      din_q         <= din_s;
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      lcnt_q        <= lcnt_d;
      bitcnt_q      <= bitcnt_d;
      pixcnt_q      <= pixcnt_d;
      shift_q       <= shift_d;
      shadow_q      <= shadow_d;
      frame_rgb_q   <= frame_rgb_d;
      frame_valid_q <= frame_valid_d;
      frame_count_q <= frame_count_d;
      pixel_q       <= pixel_d;
      pixel_index_q <= pixel_index_d;
      pixel_valid_q <= pixel_valid_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    hcnt_d        = hcnt_q;
    lcnt_d        = lcnt_q;
    bitcnt_d      = bitcnt_q;
    pixcnt_d      = pixcnt_q;
    shift_d       = shift_q;
    shadow_d      = shadow_q;
    frame_rgb_d   = frame_rgb_q;
    frame_valid_d = 1'b0;
    frame_count_d = frame_count_q;
    pixel_d       = pixel_q;
    pixel_index_d = pixel_index_q;
    pixel_valid_d = 1'b0;
    err_d         = 1'b0;
    err_code_d    = err_code_q;
    // Assembled word if the pulse ending now is accepted as a data bit.
    word          = {shift_q, (hcnt_q >= HThr)};

    unique case (state_q)
      StSync: begin
        // Hold the frame context empty until the line has idled long enough.
        bitcnt_d = '0;
        pixcnt_d = '0;
        shadow_d = '0;
        if (din_s) begin
          lcnt_d = '0;
        end else if (lcnt_q == LReset) begin
          state_d = StReady;
        end else begin
          lcnt_d = lcnt_q + 16'd1;
        end
      end

      StReady: begin
        if (rise) begin
          hcnt_d  = 8'd1;
          state_d = StHigh;
        end
      end

      StHigh: begin
        // Stuck-high wins even when the fall arrives in the same cycle.
        if (hcnt_q > HMax) begin
          err_d      = 1'b1;
          err_code_d = 2'b10;
          lcnt_d     = '0;
          state_d    = StSync;
        end else if (fall) begin
          lcnt_d  = 16'd1;
          state_d = StLow;
          if (hcnt_q < HMin) begin
            err_d      = 1'b1;
            err_code_d = 2'b01;
          end else if (bitcnt_q == 5'd23) begin
            bitcnt_d = '0;
            pixel_d  = word;
            if (pixcnt_q < NLeds) begin
              pixel_index_d = pixcnt_q;
              pixel_valid_d = 1'b1;
              for (int i = 0; i < NUM_LEDS; i++) begin
                if (pixcnt_q == 8'(i)) shadow_d[FW-1-24*i -: 24] = word;
              end
            end
            if (pixcnt_q != 8'hFF) pixcnt_d = pixcnt_q + 8'd1;
          end else begin
            shift_d  = word[22:0];
            bitcnt_d = bitcnt_q + 5'd1;
          end
        end else if (hcnt_q != HSat) begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end

      StLow: begin
        if (lcnt_q == LReset) begin
          frame_rgb_d   = shadow_q;
          frame_count_d = (pixcnt_q > NLeds) ? NLeds : pixcnt_q;
          frame_valid_d = 1'b1;
          if (bitcnt_q != 5'd0) begin
            err_d      = 1'b1;
            err_code_d = 2'b11;
          end
          bitcnt_d = '0;
          pixcnt_d = '0;
          shadow_d = '0;
          // A coincident rise starts the next frame straight away.
          if (rise) begin
            hcnt_d  = 8'd1;
            state_d = StHigh;
          end else begin
            state_d = StReady;
          end
        end else if (rise) begin
          hcnt_d  = 8'd1;
          state_d = StHigh;
        end else begin
          lcnt_d = lcnt_q + 16'd1;
        end
      end

      default: state_d = StSync;
    endcase
  end

  assign frame_rgb   = frame_rgb_q;
  assign frame_valid = frame_valid_q;
  assign frame_count = frame_count_q;
  assign pixel       = pixel_q;
  assign pixel_index = pixel_index_q;
  assign pixel_valid = pixel_valid_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: drives pulse trains and compares captured pixel, frame
// and error events against a pulse-width reference model.
module tb_ws2812_rx;

  localparam int N  = 6;
  localparam int FW = 24 * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          din;
  logic [FW-1:0] frame_rgb;
  logic          frame_valid;
  logic [7:0]    frame_count;
  logic [23:0]   pixel;
  logic [7:0]    pixel_index;
  logic          pixel_valid;
  logic          err;
  logic [1:0]    err_code;

  ws2812_rx #(
    .NUM_LEDS    (N),
    .MIN_HIGH    (6),
    .BIT_THRESH  (29),
    .MAX_HIGH    (96),
    .RESET_CYCLES(2400)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .frame_rgb  (frame_rgb),
    .frame_valid(frame_valid),
    .frame_count(frame_count),
    .pixel      (pixel),
    .pixel_index(pixel_index),
    .pixel_valid(pixel_valid),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0]  idx;
    logic [23:0] val;
  } pix_t;

  typedef struct packed {
    logic [FW-1:0] rgb;
    logic [7:0]    cnt;
    logic          e;
    logic [1:0]    code;
    int            at;
  } frm_t;

  pix_t       got_pix[$], exp_pix[$];
  frm_t       got_frm[$];
  logic [1:0] got_err[$], exp_err[$];
  int         wq[$], gq[$];
  logic [FW-1:0] exp_rgb;
  int         exp_cnt;
  bit         exp_partial;
  int         last_fall;
  int         n_checks = 0;
  int         n_bad = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (pixel_valid) got_pix.push_back(pix_t'({pixel_index, pixel}));
      if (frame_valid) got_frm.push_back(frm_t'({frame_rgb, frame_count, err, err_code, cyc}));
      if (err) got_err.push_back(err_code);
    end
  end

  task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stim();
    wq.delete();
    gq.delete();
  endtask

  task automatic push_pulse(input int w, input int g);
    wq.push_back(w);
    gq.push_back(g);
  endtask

  // nb bits of v from bit 23 down, random widths on either side of the threshold.
  task automatic push_bits(input logic [23:0] v, input int nb, input bit glitches);
    for (int j = 23; j >= 24 - nb; j--) begin
      if (glitches && $urandom_range(0, 11) == 0)
        push_pulse(int'($urandom_range(1, 5)), int'($urandom_range(3, 20)));
      if (v[j]) push_pulse(int'($urandom_range(29, 70)), int'($urandom_range(3, 20)));
      else      push_pulse(int'($urandom_range(6, 28)), int'($urandom_range(3, 20)));
    end
  endtask

  task automatic push_fixed(input logic [23:0] v);
    for (int j = 23; j >= 0; j--) push_pulse(v[j] ? 38 : 19, v[j] ? 22 : 41);
  endtask

  // Decode the queued widths by the protocol rules: <6 glitch, >=29 one.
  task automatic run_model();
    bit          bits[$];
    int          npix;
    logic [23:0] v;
    exp_pix.delete();
    exp_err.delete();
    exp_rgb = '0;
    foreach (wq[i]) begin
      if (wq[i] < 6) exp_err.push_back(2'b01);
      else           bits.push_back(wq[i] >= 29);
    end
    npix = bits.size() / 24;
    for (int k = 0; k < npix && k < N; k++) begin
      v = '0;
      for (int j = 0; j < 24; j++) v = {v[22:0], bits[k*24+j]};
      exp_pix.push_back(pix_t'({8'(k), v}));
      exp_rgb[FW-1-24*k -: 24] = v;
    end
    exp_cnt     = (npix < N) ? npix : N;
    exp_partial = (bits.size() % 24) != 0;
    if (exp_partial) exp_err.push_back(2'b11);
  endtask

  task automatic play(input int from, input int to);
    for (int i = from; i < to; i++) begin
      din = 1'b1;
      repeat (wq[i]) @(negedge clk);
      din = 1'b0;
      last_fall = cyc;
      repeat (gq[i]) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_check(input string tag, input int exp_nfrm, input bit chk_lat);
    check({tag, ".npix"}, FW'(got_pix.size()), FW'(exp_pix.size()));
    for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++)
      check({tag, ".pix"}, FW'(got_pix[i]), FW'(exp_pix[i]));
    check({tag, ".nframe"}, FW'(got_frm.size()), FW'(exp_nfrm));
    if (exp_nfrm > 0 && got_frm.size() > 0) begin
      check({tag, ".rgb"}, got_frm[0].rgb, exp_rgb);
      check({tag, ".count"}, FW'(got_frm[0].cnt), FW'(exp_cnt));
      check({tag, ".frame_err"}, FW'(got_frm[0].e), FW'(exp_partial));
      if (exp_partial) check({tag, ".frame_code"}, FW'(got_frm[0].code), FW'(2'b11));
      if (chk_lat) check({tag, ".latency"}, FW'(got_frm[0].at - last_fall), FW'(2403));
    end
    check({tag, ".nerr"}, FW'(got_err.size()), FW'(exp_err.size()));
    for (int i = 0; i < exp_err.size() && i < got_err.size(); i++)
      check({tag, ".err_code"}, FW'(got_err[i]), FW'(exp_err[i]));
    got_pix.delete();
    got_frm.delete();
    got_err.delete();
  endtask

  task automatic random_frame(input string tag, input int npix, input bit glitches);
    clear_stim();
    for (int p = 0; p < npix; p++) push_bits(24'($urandom), 24, glitches);
    run_model();
    play(0, wq.size());
    idle(2450);
    frame_check(tag, 1, 1);
  endtask

  initial begin
    int cut;
    rst = 1'b1;
    din = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.frame_rgb", frame_rgb, '0);
    check("rst.frame_valid", FW'(frame_valid), '0);
    check("rst.frame_count", FW'(frame_count), '0);
    check("rst.pixel", FW'(pixel), '0);
    check("rst.pixel_index", FW'(pixel_index), '0);
    check("rst.pixel_valid", FW'(pixel_valid), '0);
    check("rst.err", FW'(err), '0);
    check("rst.err_code", FW'(err_code), '0);
    rst = 1'b0;
    idle(2450);

    // Fixed six-pixel frame with 38/19-cycle highs in 60-cycle periods.
    clear_stim();
    push_fixed(24'hFF0000);
    push_fixed(24'h00FF00);
    push_fixed(24'h0000FF);
    push_fixed(24'h123456);
    push_fixed(24'hABCDEF);
    push_fixed(24'h000001);
    run_model();
    play(0, wq.size());
    idle(2450);
    if (got_frm.size() > 0)
      check("fixed.literal", got_frm[0].rgb, 144'hFF000000FF000000FF123456ABCDEF000001);
    frame_check("fixed", 1, 1);

    // Width boundaries: 28 -> 0, glitch 5, 29 -> 1, 96 -> 1, 6 -> 0.
    clear_stim();
    push_pulse(28, 30);
    push_pulse(5, 20);
    push_pulse(29, 30);
    push_pulse(96, 10);
    push_pulse(6, 20);
    push_bits(24'($urandom), 20, 1'b0);
    run_model();
    play(0, wq.size());
    idle(2450);
    if (got_pix.size() > 0) check("thr.top4", FW'(got_pix[0].val[23:20]), FW'(4'b0110));
    frame_check("thr", 1, 0);

    // Two pixels plus twelve stray bits.
    clear_stim();
    push_bits(24'($urandom), 24, 1'b0);
    push_bits(24'($urandom), 24, 1'b0);
    push_bits(24'($urandom), 12, 1'b0);
    run_model();
    play(0, wq.size());
    idle(2450);
    frame_check("partial", 1, 0);

    random_frame("overflow", 8, 1'b0);
    random_frame("rand0", int'($urandom_range(1, 6)), 1'b1);
    random_frame("rand1", int'($urandom_range(1, 6)), 1'b1);

    // Stuck high after one pixel and five bits.
    clear_stim();
    push_bits(24'($urandom), 24, 1'b0);
    push_bits(24'($urandom), 5, 1'b0);
    run_model();
    exp_err.delete();
    exp_err.push_back(2'b10);
    play(0, wq.size());
    din = 1'b1;
    repeat (100) @(negedge clk);
    idle(2500);
    frame_check("stuck", 0, 0);
    random_frame("after_stuck", 3, 1'b0);

    // Reset in the middle of pixel 3; the rest of that frame must be ignored.
    clear_stim();
    for (int p = 0; p < 6; p++) push_bits(24'($urandom), 24, 1'b0);
    cut = 3 * 24 + 10;
    play(0, cut);
    rst = 1'b1;
    #1;
    check("mid_rst.frame_rgb", frame_rgb, '0);
    check("mid_rst.frame_count", FW'(frame_count), '0);
    check("mid_rst.pixel", FW'(pixel), '0);
    check("mid_rst.err_code", FW'(err_code), '0);
    @(negedge clk);
    rst = 1'b0;
    got_pix.delete();
    got_frm.delete();
    got_err.delete();
    play(cut, wq.size());
    idle(2500);
    check("mid_rst.npix", FW'(got_pix.size()), '0);
    check("mid_rst.nframe", FW'(got_frm.size()), '0);
    check("mid_rst.nerr", FW'(got_err.size()), '0);
    got_pix.delete();
    got_frm.delete();
    got_err.delete();
    random_frame("after_rst", 3, 1'b0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
